// File: rtl/nspi_frame_tx.sv
// nspi_frame_tx: multi-lane SPI (mode 0) transmitter with chip-select framing.
// A one-word holding register feeds a per-lane shifter, so the next word can be
// accepted while the current one shifts out. Words then stream back to back
// inside a frame. After FRAME_WORDS words, cs_n is raised for a latch interval
// and frame_done pulses once.
module nspi_frame_tx #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned FRAME_WORDS  = 16,
  parameter int unsigned LATCH_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [CHANNELS*WORD_WIDTH-1:0] s_data,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           spi_clk,
  output logic                           spi_cs_n,
  output logic [CHANNELS-1:0]            spi_mosi
);

  localparam int unsigned DataW    = CHANNELS * WORD_WIDTH;
  // Counters are sized to hold the last value only. A minimum of 1 bit keeps
  // the degenerate parameter values (1) legal.
  localparam int unsigned HalfW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int unsigned WordCntW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned LatchW   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [HalfW-1:0]    HalfLast  = HalfW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]     BitLast   = BitW'(WORD_WIDTH - 1);
  localparam logic [WordCntW-1:0] WordLast  = WordCntW'(FRAME_WORDS - 1);
  localparam logic [LatchW-1:0]   LatchLast = LatchW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StStall,
    StLatch
  } state_e;

  state_e              state;
  logic                hold_full;
  logic [DataW-1:0]    hold_data;
  logic [DataW-1:0]    shreg;
  logic [DataW-1:0]    shreg_next;
  logic [HalfW-1:0]    half_cnt;
  logic [BitW-1:0]     bit_cnt;
  logic [WordCntW-1:0] word_cnt;
  logic [LatchW-1:0]   latch_cnt;

  logic accept;
  logic load;
  logic half_end;
  logic bit_last;
  logic word_last;
  logic latch_end;
  logic hold_full_d;
  logic idle_next;
  logic busy_d;

  // Bit currently presented by each lane: the word's leading end.
  function automatic logic [CHANNELS-1:0] lead_bits(input logic [DataW-1:0] d);
    logic [CHANNELS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (MSB_FIRST != 0) begin
        r[i] = d[i*WORD_WIDTH + WORD_WIDTH - 1];
      end else begin
        r[i] = d[i*WORD_WIDTH];
      end
    end
    return r;
  endfunction

  // Move every lane's next bit into its leading position.
  function automatic logic [DataW-1:0] shift_lanes(input logic [DataW-1:0] d);
    logic [DataW-1:0]      r;
    logic [WORD_WIDTH-1:0] w;
    r = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w = d[i*WORD_WIDTH +: WORD_WIDTH];
      if (MSB_FIRST != 0) begin
        r[i*WORD_WIDTH +: WORD_WIDTH] = w << 1;
      end else begin
        r[i*WORD_WIDTH +: WORD_WIDTH] = w >> 1;
      end
    end
    return r;
  endfunction

  assign accept     = s_valid & s_ready;
  assign half_end   = (half_cnt == HalfLast);
  assign bit_last   = (bit_cnt == BitLast);
  assign word_last  = (word_cnt == WordLast);
  assign latch_end  = (latch_cnt == LatchLast);
  assign shreg_next = shift_lanes(shreg);

  // Decide when the shifter takes the held word: from idle, out of a stall, or
  // seamlessly at the end of a non-final word.
  always_comb begin
    load = 1'b0;
    case (state)
      StIdle, StStall: load = hold_full;
      StHigh:          load = hold_full & half_end & bit_last & ~word_last;
      default:         load = 1'b0;
    endcase
  end

  // Next-cycle holding flag and busy.
  // accept and load never coincide: accept needs an empty holding register.
  always_comb begin
    hold_full_d = accept | (hold_full & ~load);
    idle_next   = ((state == StIdle) & ~hold_full) | ((state == StLatch) & latch_end);
    busy_d      = ~idle_next | hold_full_d;
  end

  // Holding register with registered ready and busy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      s_ready   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      hold_full <= hold_full_d;
      s_ready   <= ~hold_full_d;
      busy      <= busy_d;
      if (accept) begin
        hold_data <= s_data;
      end
    end
  end

  // Sequencer. Every SPI output is a register, written on the transition into
  // the state that defines it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      shreg      <= '0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      latch_cnt  <= '0;
      frame_done <= 1'b0;
      spi_clk    <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_mosi   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        StIdle: begin
          if (hold_full) begin
            word_cnt <= '0;
          end
        end
        StLow: begin
          if (half_end) begin
            half_cnt <= '0;
            spi_clk  <= 1'b1;
            state    <= StHigh;
          end else begin
            half_cnt <= half_cnt + HalfW'(1);
          end
        end
        StHigh: begin
          if (!half_end) begin
            half_cnt <= half_cnt + HalfW'(1);
          end else begin
            half_cnt <= '0;
            spi_clk  <= 1'b0;
            if (!bit_last) begin
              bit_cnt  <= bit_cnt + BitW'(1);
              shreg    <= shreg_next;
              spi_mosi <= lead_bits(shreg_next);
              state    <= StLow;
            end else if (word_last) begin
              spi_cs_n   <= 1'b1;
              spi_mosi   <= '0;
              frame_done <= 1'b1;
              latch_cnt  <= '0;
              state      <= StLatch;
            end else begin
              // A pending word overrides this via the load path below.
              word_cnt <= word_cnt + WordCntW'(1);
              spi_mosi <= '0;
              state    <= StStall;
            end
          end
        end
        StStall: begin
          // Lines already parked; wait for the load path.
        end
        StLatch: begin
          if (latch_end) begin
            state <= StIdle;
          end else begin
            latch_cnt <= latch_cnt + LatchW'(1);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase

      // Shared word-load path; last assignment wins over the case above.
      if (load) begin
        shreg    <= hold_data;
        spi_mosi <= lead_bits(hold_data);
        spi_cs_n <= 1'b0;
        spi_clk  <= 1'b0;
        half_cnt <= '0;
        bit_cnt  <= '0;
        state    <= StLow;
      end
    end
  end

endmodule

// File: tb/tb_nspi_frame_tx.sv
// Bench for nspi_frame_tx. The main instance is checked by a protocol monitor
// that rebuilds words from the SPI lines and compares them with the accepted
// words. Two small instances cover LSB-first order and the minimum parameter
// values against a per-cycle waveform formula.
module tb_nspi_frame_tx;

  localparam int ACh = 3, AW = 8, ADiv = 2, AFw = 2, ALatch = 4;
  localparam int BW = 8, BLatch = 2;
  localparam int CW = 1, CLatch = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CH=3, W=8, DIV=2, FW=2, MSB first.
  logic                a_valid = 1'b0;
  logic [ACh*AW-1:0]   a_data  = '0;
  logic                a_ready, a_busy, a_done, a_sclk, a_cs_n;
  logic [ACh-1:0]      a_mosi;
  // Instance B: CH=1, W=8, DIV=1, FW=1, LSB first.
  logic                b_valid = 1'b0;
  logic [BW-1:0]       b_data  = '0;
  logic                b_ready, b_busy, b_done, b_sclk, b_cs_n;
  logic [0:0]          b_mosi;
  // Instance C: CH=1, W=1, DIV=1, FW=1.
  logic                c_valid = 1'b0;
  logic [CW-1:0]       c_data  = '0;
  logic                c_ready, c_busy, c_done, c_sclk, c_cs_n;
  logic [0:0]          c_mosi;

  nspi_frame_tx #(
    .CHANNELS(ACh), .WORD_WIDTH(AW), .CLK_DIV(ADiv), .MSB_FIRST(1),
    .FRAME_WORDS(AFw), .LATCH_CYCLES(ALatch)
  ) u_dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .busy(a_busy), .frame_done(a_done), .spi_clk(a_sclk), .spi_cs_n(a_cs_n),
    .spi_mosi(a_mosi)
  );

  nspi_frame_tx #(
    .CHANNELS(1), .WORD_WIDTH(BW), .CLK_DIV(1), .MSB_FIRST(0),
    .FRAME_WORDS(1), .LATCH_CYCLES(BLatch)
  ) u_dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .busy(b_busy), .frame_done(b_done), .spi_clk(b_sclk), .spi_cs_n(b_cs_n),
    .spi_mosi(b_mosi)
  );

  nspi_frame_tx #(
    .CHANNELS(1), .WORD_WIDTH(CW), .CLK_DIV(1), .MSB_FIRST(1),
    .FRAME_WORDS(1), .LATCH_CYCLES(CLatch)
  ) u_dut_c (
    .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data),
    .busy(c_busy), .frame_done(c_done), .spi_clk(c_sclk), .spi_cs_n(c_cs_n),
    .spi_mosi(c_mosi)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: words accepted by instance A, in order.
  logic [ACh*AW-1:0] a_exp_q[$];
  logic expect_tight = 1'b0;

  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) a_exp_q.push_back(a_data);
  end

  // Monitor for instance A: frame structure, timing and word reassembly.
  logic              m_prev_clk, m_prev_cs, m_after_frame;
  logic [ACh-1:0]    m_prev_mosi, m_hold;
  logic [ACh*AW-1:0] m_cap;
  int                m_bit, m_words, m_len, m_hi, m_lo, m_cs_hi;

  always @(negedge clk) begin
    if (rst) begin
      m_prev_clk = 1'b0; m_prev_cs = 1'b1; m_after_frame = 1'b0;
      m_prev_mosi = '0; m_hold = '0; m_cap = '0;
      m_bit = 0; m_words = 0; m_len = 0; m_hi = 0; m_lo = 0; m_cs_hi = 0;
    end else begin
      if (a_cs_n) begin
        check("a idle lines", 32'({a_sclk, a_mosi}), 32'(0));
        if (!m_prev_cs) begin
          check("a last high run", 32'(m_hi), 32'(ADiv));
          check("a words per frame", 32'(m_words), 32'(AFw));
          check("a partial word", 32'(m_bit), 32'(0));
          check("a frame_done at end", 32'(a_done), 32'(1));
          if (expect_tight) check("a frame length", 32'(m_len), 32'(AFw * AW * 2 * ADiv));
          m_after_frame = 1'b1;
          m_cs_hi = 0;
        end else begin
          check("a frame_done quiet", 32'(a_done), 32'(0));
        end
        m_cs_hi++;
      end else begin
        if (m_prev_cs) begin
          if (m_after_frame) check("a latch gap", 32'(m_cs_hi >= ALatch), 32'(1));
          m_words = 0; m_bit = 0; m_len = 0; m_hi = 0; m_lo = 0;
        end
        m_len++;
        check("a busy in frame", 32'({a_busy, a_done}), 32'(2));
        if (a_sclk) begin
          if (!m_prev_clk) begin
            check("a low run", 32'((m_bit == 0) ? (m_lo >= ADiv) : (m_lo == ADiv)), 32'(1));
            check("a mosi settled", 32'(a_mosi), 32'(m_prev_mosi));
            m_hold = a_mosi;
            m_hi = 0;
            for (int l = 0; l < ACh; l++) begin
              m_cap[l*AW +: AW] = {m_cap[l*AW +: AW-1], a_mosi[l]};
            end
            m_bit++;
            if (m_bit == AW) begin
              m_bit = 0;
              m_words++;
              if (a_exp_q.size() == 0) check("a word expected", 32'(0), 32'(1));
              else check("a word", 32'(m_cap), 32'(a_exp_q.pop_front()));
            end
          end
          check("a mosi steady high", 32'(a_mosi), 32'(m_hold));
          m_hi++;
        end else begin
          if (m_prev_clk) begin
            check("a high run", 32'(m_hi), 32'(ADiv));
            m_lo = 0;
          end
          m_lo++;
        end
      end
      m_prev_clk = a_sclk; m_prev_cs = a_cs_n; m_prev_mosi = a_mosi;
    end
  end

  // Offer one word to A and hold it until taken; returns one cycle after.
  task automatic a_put(input logic [ACh*AW-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ready && n < 1000);
    if (n >= 1000) check("a put timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_busy == 1'b0 && a_cs_n == 1'b1) && n < 3000);
    check(tag, 32'(n < 3000), 32'(1));
  endtask

  task automatic small_sample(input int which, output logic sc, output logic cs,
                              output logic mo, output logic dn, output logic rd);
    if (which == 0) begin
      sc = b_sclk; cs = b_cs_n; mo = b_mosi[0]; dn = b_done; rd = b_ready;
    end else begin
      sc = c_sclk; cs = c_cs_n; mo = c_mosi[0]; dn = c_done; rd = c_ready;
    end
  endtask

  // One word through B or C, checked cycle by cycle against the waveform
  // implied by DIV=1: low/high alternate every clk, bit k/2 on the lane.
  task automatic run_small(input int which, input logic [7:0] w);
    int   wid, lat, b;
    logic msb, sc, cs, mo, dn, rd, em;
    wid = (which == 0) ? BW : CW;
    lat = (which == 0) ? BLatch : CLatch;
    msb = (which != 0);
    @(posedge clk); #1;
    if (which == 0) begin b_valid = 1'b1; b_data = w; end
    else begin c_valid = 1'b1; c_data = w[0]; end
    @(negedge clk);
    small_sample(which, sc, cs, mo, dn, rd);
    check("small ready", 32'(rd), 32'(1));
    @(posedge clk); #1;
    b_valid = 1'b0;
    c_valid = 1'b0;
    @(negedge clk);
    small_sample(which, sc, cs, mo, dn, rd);
    check("small load cycle", 32'({cs, sc, rd}), 32'(3'b100));
    for (int k = 0; k < 2 * wid; k++) begin
      @(negedge clk);
      small_sample(which, sc, cs, mo, dn, rd);
      b  = k / 2;
      em = msb ? w[wid-1-b] : w[b];
      check("small cs", 32'(cs), 32'(0));
      check("small sclk", 32'(sc), 32'(k % 2));
      check("small mosi", 32'(mo), 32'(em));
    end
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      small_sample(which, sc, cs, mo, dn, rd);
      check("small latch", 32'({cs, sc, mo}), 32'(3'b100));
      check("small done", 32'(dn), 32'(j == 0));
    end
    @(negedge clk);
    small_sample(which, sc, cs, mo, dn, rd);
    check("small idle", 32'({cs, sc, mo, dn}), 32'(4'b1000));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int   got_n, cyc, acc, dones, rises;
    logic took, prev_took, prev_sc;

    // Reset values.
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst a lines", 32'({a_cs_n, a_sclk, a_mosi}), 32'(5'b10000));
    check("rst a flags", 32'({a_ready, a_busy, a_done}), 32'(3'b100));
    check("rst b lines", 32'({b_cs_n, b_sclk, b_mosi, b_ready, b_busy}), 32'(5'b10010));
    check("rst c lines", 32'({c_cs_n, c_sclk, c_mosi, c_ready, c_busy}), 32'(5'b10010));
    @(posedge clk); #1;
    rst = 1'b0;

    // Two fixed words, second offered right after the first is loaded.
    expect_tight = 1'b1;
    a_put({8'hFF, 8'h3C, 8'hA5});
    @(negedge clk);
    check("a load cycle cs", 32'(a_cs_n), 32'(1));
    check("a ready after accept", 32'({a_ready, a_busy}), 32'(2'b01));
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = {8'h00, 8'h80, 8'h01};
    @(negedge clk);
    check("a first bit latency", 32'({a_cs_n, a_sclk, a_mosi}), 32'(5'b00101));
    check("a ready refilled", 32'(a_ready), 32'(1));
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_a_idle("a idle after fixed frame");

    // Second word withheld: stall keeps cs_n low and clock parked.
    expect_tight = 1'b0;
    a_put(24'($urandom));
    repeat (40) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("a stall lines", 32'({a_cs_n, a_sclk, a_mosi}), 32'(0));
    end
    a_put(24'($urandom));
    wait_a_idle("a idle after stall frame");

    // s_valid held high; data scrambled every cycle, only handshakes count.
    expect_tight = 1'b1;
    got_n = 0; cyc = 0; prev_took = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = 24'($urandom);
    while (got_n < 8 && cyc < 3000) begin
      @(negedge clk);
      if (prev_took) check("a ready clears", 32'(a_ready), 32'(0));
      took = a_valid & a_ready;
      prev_took = took;
      @(posedge clk); #1;
      cyc++;
      if (took) got_n++;
      a_data = 24'($urandom);
      if (got_n == 8) a_valid = 1'b0;
    end
    a_valid = 1'b0;
    check("a stream count", 32'(got_n), 32'(8));
    wait_a_idle("a idle after stream");

    // Sparse random offers: mix of seamless words and stalls.
    expect_tight = 1'b0;
    got_n = 0; cyc = 0;
    while (got_n < 20 && cyc < 20000) begin
      @(posedge clk); #1;
      a_valid = ($urandom_range(0, 31) == 0);
      a_data  = 24'($urandom);
      @(negedge clk);
      if (a_valid && a_ready) got_n++;
      cyc++;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("a random count", 32'(got_n), 32'(20));
    wait_a_idle("a idle after random");

    // Reset during bit 3 of the second word; the aborted frame must not resume.
    a_put(24'($urandom));
    a_put(24'($urandom));
    repeat (44) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst mid lines", 32'({a_cs_n, a_sclk, a_mosi}), 32'(5'b10000));
    check("rst mid flags", 32'({a_ready, a_busy, a_done}), 32'(3'b100));
    @(negedge clk);
    a_exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    expect_tight = 1'b1;
    a_put(24'($urandom));
    a_put(24'($urandom));
    wait_a_idle("a idle after reset frame");
    check("a queue drained", 32'(a_exp_q.size()), 32'(0));

    // LSB-first lane and minimum-size instance.
    run_small(0, 8'h01);
    run_small(0, 8'($urandom));
    run_small(0, 8'($urandom));
    run_small(1, 8'h01);
    run_small(1, 8'h00);

    // C streamed: one frame and one frame_done per single-bit word.
    acc = 0; dones = 0; rises = 0; prev_sc = 1'b0;
    @(posedge clk); #1;
    c_valid = 1'b1;
    c_data  = 1'($urandom);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (c_valid && c_ready) acc++;
      dones += int'(c_done);
      rises += int'(c_sclk && !prev_sc);
      prev_sc = c_sclk;
      @(posedge clk); #1;
      c_data = 1'($urandom);
      if (acc == 3) c_valid = 1'b0;
    end
    c_valid = 1'b0;
    check("c stream frames", 32'(dones), 32'(3));
    check("c stream clocks", 32'(rises), 32'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
